// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Brief    : Fetch-stage program counter sequencer. Issues one instruction
//             fetch per cycle, holds on ID stalls, applies branch redirects
//             (immediately or deferred until the outstanding fetch is acked)
//             and parks in HALT until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        halt,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] pc,
    output logic        flush,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [15:0] c_pc_step = 16'(PC_STEP);

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_redir_tgt;
    logic        r_redir_pend;
    logic        r_halt_pend;
    logic        r_flush;
    logic        r_imem_req;
    logic        r_halted;

    logic        w_taken;
    logic [15:0] w_br_tgt;
    logic [15:0] w_pc_inc;

    // Branch decode, word alignment of targets and the wrapping PC increment.
    assign w_taken  = br_valid & br_taken;
    assign w_br_tgt = br_target & 16'hFFFE;
    assign w_pc_inc = r_pc + c_pc_step;

    // Sequencer FSM: state, PC, redirect/halt bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_redir_tgt  <= 16'h0000;
            r_redir_pend <= 1'b0;
            r_halt_pend  <= 1'b0;
            r_flush      <= 1'b0;
            r_imem_req   <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            // flush is a single-cycle pulse unless a redirect re-arms it
            r_flush <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end

                S_FETCH: begin
                    if (!imem_ack) begin
                        // Fetch still outstanding: address stays put, remember
                        // any halt or redirect until the word comes back.
                        if (halt) begin
                            r_halt_pend <= 1'b1;
                        end
                        if (w_taken) begin
                            r_redir_tgt  <= w_br_tgt;
                            r_redir_pend <= 1'b1;
                        end
                    end else if (halt || r_halt_pend) begin
                        // Halt beats any redirect; the redirect is dropped.
                        r_state      <= S_HALT;
                        r_imem_req   <= 1'b0;
                        r_halted     <= 1'b1;
                        r_halt_pend  <= 1'b0;
                        r_redir_pend <= 1'b0;
                    end else if (w_taken) begin
                        // A fresh branch supersedes any older pending target.
                        r_pc         <= w_br_tgt;
                        r_flush      <= 1'b1;
                        r_redir_pend <= 1'b0;
                    end else if (r_redir_pend) begin
                        r_pc         <= r_redir_tgt;
                        r_flush      <= 1'b1;
                        r_redir_pend <= 1'b0;
                    end else if (stall) begin
                        r_state    <= S_HOLD;
                        r_imem_req <= 1'b0;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end

                S_HOLD: begin
                    if (halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (w_taken) begin
                        // Redirect wins over a still-asserted stall.
                        r_pc       <= w_br_tgt;
                        r_flush    <= 1'b1;
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end else if (!stall) begin
                        r_pc       <= w_pc_inc;
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end

                S_HALT: begin
                    // Parked until reset.
                    r_imem_req <= 1'b0;
                    r_halted   <= 1'b1;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign imem_req  = r_imem_req;
    assign flush     = r_flush;
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Brief    : Directed self-checking bench for pc_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic [15:0] br_target;
    logic        halt;
    logic        imem_ack;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] pc;
    logic        flush;
    logic        halted;

    int n_checks;
    int n_fail;

    pc_sequencer #(
        .RESET_PC (16'h0000),
        .PC_STEP  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .br_target (br_target),
        .halt      (halt),
        .imem_ack  (imem_ack),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .pc        (pc),
        .flush     (flush),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one cycle and sample 1 time unit after the rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        stall     = 1'b0;
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        br_target = 16'h0000;
        halt      = 1'b0;
        imem_ack  = 1'b0;
    endtask

    task automatic run_fetches(input int n);
        imem_ack = 1'b1;
        for (int k = 0; k < n; k++) tick();
        imem_ack = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();          // IDLE -> FETCH
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (pc !== 16'h0000 || imem_req !== 1'b0 || flush !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h req=%b flush=%b halted=%b, required pc=0000 req=0 flush=0 halted=0",
                     pc, imem_req, flush, halted);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: req=%b required 0", imem_req);
        end
    endtask

    // ack tied high from reset release: 0000, 0002, 0004, ... up to 0010
    task automatic test_sequential;
        imem_ack = 1'b1;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL first_fetch: req=%b addr=%h required req=1 addr=0000", imem_req, imem_addr);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (imem_addr !== 16'(2 * i) || imem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_fetch[%0d]: addr=%h req=%b required addr=%h req=1",
                         i, imem_addr, imem_req, 16'(2 * i));
            end
        end
    endtask

    // pc=0010: ack with stall, three HOLD cycles, then resume at 0012
    task automatic test_stall;
        imem_ack = 1'b1;
        stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            imem_ack = 1'b0;
            n_checks++;
            if (imem_req !== 1'b0 || pc !== 16'h0010 || flush !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d]: req=%b pc=%h flush=%b required req=0 pc=0010 flush=0",
                         i, imem_req, pc, flush);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0012) begin
            n_fail++;
            $display("FAIL hold_release: req=%b addr=%h required req=1 addr=0012", imem_req, imem_addr);
        end
    endtask

    // addr stable while ack is low
    task automatic test_wait_state;
        imem_ack = 1'b0;
        tick();
        tick();
        n_checks++;
        if (imem_addr !== 16'h0012 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_stable: addr=%h req=%b required addr=0012 req=1", imem_addr, imem_req);
        end
    endtask

    // pc=0020: acked taken branch to 0101 -> flush once, addr 0100
    task automatic test_branch_ack;
        run_fetches(7);
        n_checks++;
        if (pc !== 16'h0020) begin
            n_fail++;
            $display("FAIL pre_branch_pc: pc=%h required 0020", pc);
        end
        imem_ack  = 1'b1;
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'h0101;
        tick();
        br_valid = 1'b0;
        br_taken = 1'b0;
        imem_ack = 1'b0;
        n_checks++;
        if (flush !== 1'b1 || imem_addr !== 16'h0100) begin
            n_fail++;
            $display("FAIL branch_ack: flush=%b addr=%h required flush=1 addr=0100", flush, imem_addr);
        end
        tick();
        n_checks++;
        if (flush !== 1'b0 || imem_addr !== 16'h0100) begin
            n_fail++;
            $display("FAIL branch_flush_once: flush=%b addr=%h required flush=0 addr=0100", flush, imem_addr);
        end
        // not-taken resolution is transparent
        imem_ack  = 1'b1;
        br_valid  = 1'b1;
        br_taken  = 1'b0;
        br_target = 16'h0500;
        tick();
        br_valid = 1'b0;
        imem_ack = 1'b0;
        n_checks++;
        if (flush !== 1'b0 || pc !== 16'h0102) begin
            n_fail++;
            $display("FAIL not_taken: flush=%b pc=%h required flush=0 pc=0102", flush, pc);
        end
    endtask

    // pc=0030, ack low: branch to 0200 pends, applied on the later ack
    task automatic test_pending_redirect;
        imem_ack  = 1'b1;
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'h0030;
        tick();
        imem_ack  = 1'b0;
        br_target = 16'h0200;
        tick();
        br_valid = 1'b0;
        br_taken = 1'b0;
        n_checks++;
        if (pc !== 16'h0030 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_capture: pc=%h flush=%b required pc=0030 flush=0", pc, flush);
        end
        tick();
        n_checks++;
        if (imem_addr !== 16'h0030 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_hold: addr=%h flush=%b required addr=0030 flush=0", imem_addr, flush);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        n_checks++;
        if (flush !== 1'b1 || imem_addr !== 16'h0200) begin
            n_fail++;
            $display("FAIL pend_apply: flush=%b addr=%h required flush=1 addr=0200", flush, imem_addr);
        end
        tick();
        n_checks++;
        if (flush !== 1'b0 || imem_addr !== 16'h0200) begin
            n_fail++;
            $display("FAIL pend_cleared: flush=%b addr=%h required flush=0 addr=0200", flush, imem_addr);
        end
        // second pending branch overwrites the first (and is aligned)
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'h0300;
        tick();
        br_target = 16'h0401;
        tick();
        br_valid = 1'b0;
        br_taken = 1'b0;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        n_checks++;
        if (pc !== 16'h0400 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_overwrite: pc=%h flush=%b required pc=0400 flush=1", pc, flush);
        end
        // ack with pending redirect and a new branch: new target wins
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'h0500;
        tick();
        imem_ack  = 1'b1;
        br_target = 16'h0600;
        tick();
        imem_ack = 1'b0;
        br_valid = 1'b0;
        br_taken = 1'b0;
        n_checks++;
        if (pc !== 16'h0600 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_new_wins: pc=%h flush=%b required pc=0600 flush=1", pc, flush);
        end
    endtask

    // branch in HOLD overrides stall; then FFFE wraps to 0000
    task automatic test_hold_branch_wrap;
        imem_ack = 1'b1;
        stall    = 1'b1;
        tick();
        imem_ack  = 1'b0;
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'hFFFF;
        tick();
        br_valid = 1'b0;
        br_taken = 1'b0;
        stall    = 1'b0;
        n_checks++;
        if (pc !== 16'hFFFE || flush !== 1'b1 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_branch: pc=%h flush=%b req=%b required pc=fffe flush=1 req=1",
                     pc, flush, imem_req);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        n_checks++;
        if (imem_addr !== 16'h0000 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap: addr=%h flush=%b required addr=0000 flush=0", imem_addr, flush);
        end
    endtask

    // halt + taken branch on same ack -> HALT, no flush; async reset exits
    task automatic test_halt;
        run_fetches(1);
        imem_ack  = 1'b1;
        halt      = 1'b1;
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'h0700;
        tick();
        idle_inputs();
        n_checks++;
        if (halted !== 1'b1 || flush !== 1'b0 || pc !== 16'h0002 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_enter: halted=%b flush=%b pc=%h req=%b required halted=1 flush=0 pc=0002 req=0",
                     halted, flush, pc, imem_req);
        end
        imem_ack = 1'b1;
        stall    = 1'b0;
        tick();
        tick();
        imem_ack = 1'b0;
        n_checks++;
        if (halted !== 1'b1 || pc !== 16'h0002 || imem_req !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_stay: halted=%b pc=%h req=%b flush=%b required halted=1 pc=0002 req=0 flush=0",
                     halted, pc, imem_req, flush);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (pc !== 16'h0000 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_async_reset: pc=%h halted=%b required pc=0000 halted=0", pc, halted);
        end
    endtask

    // halt seen while ack low is deferred until the ack
    task automatic test_halt_pending;
        do_reset();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        n_checks++;
        if (halted !== 1'b0 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_pend_wait: halted=%b req=%b required halted=0 req=1", halted, imem_req);
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        n_checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL halt_pend_take: halted=%b req=%b pc=%h required halted=1 req=0 pc=0000",
                     halted, imem_req, pc);
        end
    endtask

    // reset asserted mid-fetch drops the request at once, no flush
    task automatic test_reset_mid_fetch;
        do_reset();
        run_fetches(2);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || flush !== 1'b0 || pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: req=%b flush=%b pc=%h required req=0 flush=0 pc=0000",
                     imem_req, flush, pc);
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_wait_state();
        test_branch_ack();
        test_pending_redirect();
        test_hold_branch_wrap();
        test_halt();
        test_halt_pending();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
